// File: rtl/router_rx_depacketizer.sv
// Aurora RX depacketizer: parses a header beat, writes payload beats into BRAM
// starting at the destination address, and reports completion or frame errors.
module router_rx_depacketizer #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 12
) (
  input  logic              user_clk,
  input  logic              rst_n,
  input  logic              channel_up,
  input  logic [DATA_W-1:0] rx_tdata,
  input  logic              rx_tvalid,
  input  logic              rx_tlast,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_wdata,
  output logic              recv_done,
  output logic [9:0]        recv_src_addr,
  output logic [9:0]        recv_dst_addr,
  output logic [LEN_W-1:0]  recv_len,
  output logic              frame_err
);

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    DROP
  } state_t;

  state_t state, state_nxt;

  logic [LEN_W-1:0]  cnt, cnt_nxt;
  logic [LEN_W-1:0]  len_q, len_nxt;
  logic [9:0]        dst_q, dst_nxt;
  logic [9:0]        src_q, src_nxt;

  logic              we_nxt;
  logic              done_nxt;
  logic              err_nxt;
  logic              recv_upd;
  logic [9:0]        rdst_nxt;
  logic [9:0]        rsrc_nxt;
  logic [LEN_W-1:0]  rlen_nxt;

  logic [9:0]        hdr_dst;
  logic [9:0]        hdr_src;
  logic [LEN_W-1:0]  hdr_len;
  logic              beat;
  logic              final_beat;
  logic [ADDR_W-1:0] wr_addr;

  assign hdr_dst    = rx_tdata[9:0];
  assign hdr_src    = rx_tdata[19:10];
  assign hdr_len    = rx_tdata[20 +: LEN_W];
  assign beat       = rx_tvalid & channel_up;
  assign final_beat = (cnt == len_q - LEN_W'(1));
  // Truncating both operands to ADDR_W gives the silent modulo wrap.
  assign wr_addr    = ADDR_W'(dst_q) + ADDR_W'(cnt);

  always_ff @(posedge user_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    len_nxt   = len_q;
    dst_nxt   = dst_q;
    src_nxt   = src_q;
    we_nxt    = 1'b0;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    recv_upd  = 1'b0;
    rdst_nxt  = dst_q;
    rsrc_nxt  = src_q;
    rlen_nxt  = len_q;

    unique case (state)
      IDLE: begin
        if (beat) begin
          if (hdr_len != '0 && !rx_tlast) begin
            dst_nxt   = hdr_dst;
            src_nxt   = hdr_src;
            len_nxt   = hdr_len;
            cnt_nxt   = '0;
            state_nxt = PAYLOAD;
          end else if (hdr_len == '0 && rx_tlast) begin
            done_nxt = 1'b1;
            recv_upd = 1'b1;
            rdst_nxt = hdr_dst;
            rsrc_nxt = hdr_src;
            rlen_nxt = hdr_len;
          end else begin
            err_nxt = 1'b1;
            if (!rx_tlast) state_nxt = DROP;
          end
        end
      end

      PAYLOAD: begin
        if (!channel_up) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else if (rx_tvalid) begin
          we_nxt  = 1'b1;
          cnt_nxt = cnt + LEN_W'(1);
          if (rx_tlast) begin
            state_nxt = IDLE;
            if (final_beat) begin
              done_nxt = 1'b1;
              recv_upd = 1'b1;
            end else begin
              err_nxt = 1'b1;
            end
          end else if (final_beat) begin
            err_nxt   = 1'b1;
            state_nxt = DROP;
          end
        end
      end

      DROP: begin
        if (!channel_up) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else if (rx_tvalid && rx_tlast) begin
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge user_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= '0;
      len_q         <= '0;
      dst_q         <= '0;
      src_q         <= '0;
      bram_we       <= 1'b0;
      bram_addr     <= '0;
      bram_wdata    <= '0;
      recv_done     <= 1'b0;
      frame_err     <= 1'b0;
      recv_src_addr <= '0;
      recv_dst_addr <= '0;
      recv_len      <= '0;
    end else begin
      cnt       <= cnt_nxt;
      len_q     <= len_nxt;
      dst_q     <= dst_nxt;
      src_q     <= src_nxt;
      bram_we   <= we_nxt;
      recv_done <= done_nxt;
      frame_err <= err_nxt;
      if (we_nxt) begin
        bram_addr  <= wr_addr;
        bram_wdata <= rx_tdata;
      end
      if (recv_upd) begin
        recv_src_addr <= rsrc_nxt;
        recv_dst_addr <= rdst_nxt;
        recv_len      <= rlen_nxt;
      end
    end
  end

endmodule

// File: tb/tb_router_rx_depacketizer.sv
// Frame-level stimulus with a per-cycle expectation timeline built from the
// frame rules, compared against the depacketizer every clock.
module tb_router_rx_depacketizer;
  localparam int DATA_W = 256;
  localparam int ADDR_W = 10;
  localparam int LEN_W  = 12;

  logic              user_clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              channel_up;
  logic [DATA_W-1:0] rx_tdata;
  logic              rx_tvalid;
  logic              rx_tlast;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_wdata;
  logic              recv_done;
  logic [9:0]        recv_src_addr;
  logic [9:0]        recv_dst_addr;
  logic [LEN_W-1:0]  recv_len;
  logic              frame_err;

  always #5 user_clk = ~user_clk;

  router_rx_depacketizer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .user_clk(user_clk), .rst_n(rst_n), .channel_up(channel_up),
    .rx_tdata(rx_tdata), .rx_tvalid(rx_tvalid), .rx_tlast(rx_tlast),
    .bram_we(bram_we), .bram_addr(bram_addr), .bram_wdata(bram_wdata),
    .recv_done(recv_done), .recv_src_addr(recv_src_addr),
    .recv_dst_addr(recv_dst_addr), .recv_len(recv_len), .frame_err(frame_err)
  );

  typedef struct {
    logic cu, v, l;
    logic [DATA_W-1:0] d;
  } stim_t;

  typedef struct {
    logic we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wd;
    logic done, err;
    logic [9:0] rsrc, rdst;
    logic [LEN_W-1:0] rlen;
  } exp_t;

  stim_t stim_q[$];
  exp_t  exp_q[$];

  logic [9:0]       m_src = '0;
  logic [9:0]       m_dst = '0;
  logic [LEN_W-1:0] m_len = '0;

  int checks = 0;
  int errors = 0;
  int cur = 0;
  logic active = 1'b0;

  task automatic check(input string name, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] rnd_data();
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // One input slot plus the outputs it must produce after its clock edge.
  task automatic put(input logic cu, input logic v, input logic l, input logic [DATA_W-1:0] d,
                     input logic we, input logic [ADDR_W-1:0] a, input logic done, input logic err);
    stim_t s;
    exp_t e;
    s.cu = cu; s.v = v; s.l = l; s.d = d;
    e.we = we; e.addr = a; e.wd = d; e.done = done; e.err = err;
    e.rsrc = m_src; e.rdst = m_dst; e.rlen = m_len;
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) put(1'b1, 1'b0, 1'($urandom), rnd_data(), 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic link_idle(input int n);
    for (int i = 0; i < n; i++) put(1'b0, 1'($urandom), 1'($urandom), rnd_data(), 1'b0, '0, 1'b0, 1'b0);
  endtask

  // tlast_at < 0: tlast on header. drop_at: link lost before that beat.
  // stop_at: abandon the frame before that beat. gaps < 0: random gaps.
  task automatic frame(input logic [9:0] dst, input logic [9:0] src, input int len,
                       input int tlast_at, input int drop_at, input int stop_at, input int gaps);
    logic [DATA_W-1:0] d;
    logic last, we, done, err;
    logic [ADDR_W-1:0] a;
    d = rnd_data();
    d[9:0] = dst;
    d[19:10] = src;
    d[20 +: LEN_W] = LEN_W'(len);
    if (tlast_at < 0) begin
      if (len == 0) begin
        m_dst = dst; m_src = src; m_len = LEN_W'(len);
        put(1'b1, 1'b1, 1'b1, d, 1'b0, '0, 1'b1, 1'b0);
      end else begin
        put(1'b1, 1'b1, 1'b1, d, 1'b0, '0, 1'b0, 1'b1);
      end
      return;
    end
    put(1'b1, 1'b1, 1'b0, d, 1'b0, '0, 1'b0, len == 0);
    for (int k = 0; k <= tlast_at; k++) begin
      if (k == stop_at) return;
      idle(gaps < 0 ? int'($urandom_range(0, 2)) : gaps);
      if (k == drop_at) begin
        put(1'b0, 1'($urandom), 1'($urandom), rnd_data(), 1'b0, '0, 1'b0, 1'b1);
        return;
      end
      d = rnd_data();
      last = (k == tlast_at);
      we = (k < len);
      a = ADDR_W'((int'(dst) + k) % (1 << ADDR_W));
      done = we && last && (k == len - 1);
      err = we && ((last && k != len - 1) || (!last && k == len - 1));
      if (done) begin
        m_dst = dst; m_src = src; m_len = LEN_W'(len);
      end
      put(1'b1, 1'b1, last, d, we, we ? a : '0, done, err);
    end
  endtask

  function automatic int count_exp(input int kind);
    int n = 0;
    foreach (exp_q[i]) begin
      if (kind == 0 && exp_q[i].we) n++;
      if (kind == 1 && exp_q[i].done) n++;
      if (kind == 2 && exp_q[i].err) n++;
    end
    return n;
  endfunction

  function automatic int nth_addr(input int n);
    int c = 0;
    foreach (exp_q[i]) if (exp_q[i].we) begin
      if (c == n) return int'(exp_q[i].addr);
      c++;
    end
    return -1;
  endfunction

  task automatic run_batch();
    for (int i = 0; i < stim_q.size(); i++) begin
      @(negedge user_clk);
      channel_up = stim_q[i].cu;
      rx_tvalid  = stim_q[i].v;
      rx_tlast   = stim_q[i].l;
      rx_tdata   = stim_q[i].d;
      cur = i;
      active = 1'b1;
    end
    @(negedge user_clk);
    active = 1'b0;
    channel_up = 1'b1;
    rx_tvalid = 1'b0;
    rx_tlast = 1'b0;
    stim_q.delete();
    exp_q.delete();
  endtask

  always begin
    exp_t e;
    int k;
    @(posedge user_clk);
    if (active) begin
      k = cur;
      #1;
      e = exp_q[k];
      check("bram_we", DATA_W'(bram_we), DATA_W'(e.we));
      if (e.we) begin
        check("bram_addr", DATA_W'(bram_addr), DATA_W'(e.addr));
        check("bram_wdata", bram_wdata, e.wd);
      end
      check("recv_done", DATA_W'(recv_done), DATA_W'(e.done));
      check("frame_err", DATA_W'(frame_err), DATA_W'(e.err));
      check("recv_src", DATA_W'(recv_src_addr), DATA_W'(e.rsrc));
      check("recv_dst", DATA_W'(recv_dst_addr), DATA_W'(e.rdst));
      check("recv_len", DATA_W'(recv_len), DATA_W'(e.rlen));
      check("done_err_excl", DATA_W'(recv_done & frame_err), '0);
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"}, DATA_W'(bram_we), '0);
    check({tag, "_addr"}, DATA_W'(bram_addr), '0);
    check({tag, "_wdata"}, bram_wdata, '0);
    check({tag, "_done"}, DATA_W'(recv_done), '0);
    check({tag, "_err"}, DATA_W'(frame_err), '0);
    check({tag, "_rsrc"}, DATA_W'(recv_src_addr), '0);
    check({tag, "_rdst"}, DATA_W'(recv_dst_addr), '0);
    check({tag, "_rlen"}, DATA_W'(recv_len), '0);
  endtask

  initial begin
    int t, len, tl, dr;
    channel_up = 1'b1;
    rx_tvalid = 1'b0;
    rx_tlast = 1'b0;
    rx_tdata = '0;
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (2) @(negedge user_clk);
    rst_n = 1'b1;

    // Normal frame
    frame(10'h005, 10'h001, 3, 2, -1, -1, 0);
    check("pin_n_writes", DATA_W'(count_exp(0)), DATA_W'(3));
    check("pin_addr0", DATA_W'(nth_addr(0)), DATA_W'(10'h005));
    check("pin_addr2", DATA_W'(nth_addr(2)), DATA_W'(10'h007));
    check("pin_n_done", DATA_W'(count_exp(1)), DATA_W'(1));
    run_batch();
    check("req_dst", DATA_W'(recv_dst_addr), DATA_W'(10'h005));
    check("req_src", DATA_W'(recv_src_addr), DATA_W'(10'h001));
    check("req_len", DATA_W'(recv_len), DATA_W'(3));

    // Address wrap with gaps
    frame(10'h3FE, 10'h009, 4, 3, -1, -1, 2);
    check("pin_wrap1", DATA_W'(nth_addr(1)), DATA_W'(10'h3FF));
    check("pin_wrap2", DATA_W'(nth_addr(2)), DATA_W'(10'h000));
    check("pin_wrap3", DATA_W'(nth_addr(3)), DATA_W'(10'h001));
    run_batch();

    // Early tlast, then a normal one-beat frame
    frame(10'h010, 10'h003, 4, 1, -1, -1, 0);
    check("pin_early_writes", DATA_W'(count_exp(0)), DATA_W'(2));
    check("pin_early_err", DATA_W'(count_exp(2)), DATA_W'(1));
    frame(10'h006, 10'h004, 1, 0, -1, -1, 0);
    run_batch();
    check("early_next_dst", DATA_W'(recv_dst_addr), DATA_W'(10'h006));

    // Late tlast, then header-only
    frame(10'h020, 10'h005, 2, 3, -1, -1, 0);
    check("pin_late_writes", DATA_W'(count_exp(0)), DATA_W'(2));
    check("pin_late_err", DATA_W'(count_exp(2)), DATA_W'(1));
    frame(10'h030, 10'h006, 0, -1, -1, -1, 0);
    run_batch();
    check("hdr_only_len", DATA_W'(recv_len), '0);
    check("hdr_only_dst", DATA_W'(recv_dst_addr), DATA_W'(10'h030));

    // Link loss mid-payload, link down while idle, then a normal frame
    frame(10'h040, 10'h007, 3, 2, 1, -1, 0);
    check("pin_link_writes", DATA_W'(count_exp(0)), DATA_W'(1));
    link_idle(3);
    frame(10'h050, 10'h008, 2, 1, -1, -1, 1);
    run_batch();

    // Mid-frame reset
    frame(10'h060, 10'h00A, 5, 4, -1, 2, 0);
    run_batch();
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    m_src = '0; m_dst = '0; m_len = '0;
    @(negedge user_clk);
    rst_n = 1'b1;
    frame(10'h007, 10'h002, 1, 0, -1, -1, 0);
    run_batch();
    check("post_reset_dst", DATA_W'(recv_dst_addr), DATA_W'(10'h007));
    check("post_reset_src", DATA_W'(recv_src_addr), DATA_W'(10'h002));
    check("post_reset_len", DATA_W'(recv_len), DATA_W'(1));

    // Randomized frames
    for (int f = 0; f < 80; f++) begin
      if ($urandom_range(0, 7) == 0) link_idle(int'($urandom_range(1, 3)));
      t = int'($urandom_range(0, 6));
      dr = -1;
      case (t)
        0: begin len = int'($urandom_range(1, 12)); tl = len - 1; end
        1: begin len = int'($urandom_range(2, 6)); tl = int'($urandom_range(0, len - 2)); end
        2: begin len = int'($urandom_range(1, 4)); tl = len + int'($urandom_range(0, 3)); end
        3: begin len = 0; tl = -1; end
        4: begin len = int'($urandom_range(1, 5)); tl = -1; end
        5: begin len = 0; tl = int'($urandom_range(0, 3)); end
        default: begin len = int'($urandom_range(1, 6)); tl = len - 1; dr = int'($urandom_range(0, len - 1)); end
      endcase
      frame(10'($urandom), 10'($urandom), len, tl, dr, -1, -1);
    end
    run_batch();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
